// File: rtl/dc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dc_pkg                                                     |
// | Purpose  : Shared constants for the digital-clock display scanner:    |
// |            digit count, digit index map, seven-segment patterns.      |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package dc_pkg;

  localparam int NUM_DIGITS = 6;

  // Digit index map, rightmost digit (seconds units) is index 0
  localparam logic [2:0] DIG_SEC_U  = 3'd0;
  localparam logic [2:0] DIG_SEC_T  = 3'd1;
  localparam logic [2:0] DIG_MIN_U  = 3'd2;
  localparam logic [2:0] DIG_MIN_T  = 3'd3;
  localparam logic [2:0] DIG_HOUR_U = 3'd4;
  localparam logic [2:0] DIG_HOUR_T = 3'd5;

  // Largest legal BCD value per digit kind
  localparam logic [3:0] MAX_UNIT   = 4'd9;
  localparam logic [3:0] MAX_TEN_MS = 4'd5;
  localparam logic [3:0] MAX_TEN_H  = 4'd2;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // The colon sits in the decimal points of the minutes and hours units
  function automatic logic is_colon(input logic [2:0] idx);
    return (idx == DIG_MIN_U) || (idx == DIG_HOUR_U);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : bcd_to_seg7                                                |
// | Purpose  : Combinational BCD to active-low seven-segment encoder.     |
// |            Values above the supplied bound (or above 9) show a dash.  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module bcd_to_seg7
  import dc_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic [3:0] i_max,
  output logic [6:0] o_seg
);

  // Pattern lookup; anything outside 0..i_max falls through to the dash
  always_comb begin
    o_seg = SEG_DASH;
    if (i_value <= i_max) begin
      case (i_value)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_display_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dc_display_scan                                            |
// | Purpose  : 6-digit multiplexed common-anode display driver for the    |
// |            BCD time bus. Captures a whole-frame snapshot at the end   |
// |            of each scan so a frame never shows a torn time.           |
// | Options  : DC_COLON_BLINK_EN - colon follows snapshot sec_unit[0]     |
// |            (lit on even seconds) instead of being steady.             |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module dc_display_scan
  import dc_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_unit,
  input  logic [2:0] sec_ten,
  input  logic [3:0] min_unit,
  input  logic [2:0] min_ten,
  input  logic [3:0] hour_unit,
  input  logic [1:0] hour_ten,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic [3:0] snap_su_q, snap_su_d;
  logic [2:0] snap_st_q, snap_st_d;
  logic [3:0] snap_mu_q, snap_mu_d;
  logic [2:0] snap_mt_q, snap_mt_d;
  logic [3:0] snap_hu_q, snap_hu_d;
  logic [1:0] snap_ht_q, snap_ht_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  logic       w_tick;
  logic       w_capture;
  logic [3:0] w_dig_val;
  logic [3:0] w_dig_max;
  logic [6:0] w_enc_seg;

  // Prescaler and digit index: idx moves on once every SCAN_DIV cycles
  always_comb begin
    w_tick    = (cnt_q == CNT_LAST);
    w_capture = w_tick && (idx_q == DIG_HOUR_T);
    cnt_d     = w_tick ? '0 : cnt_q + CNT_ONE;
    idx_d     = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == DIG_HOUR_T) ? DIG_SEC_U : idx_q + 3'd1;
    end
  end

  // Snapshot load at the end of the last digit slot of a frame
  always_comb begin
    snap_su_d = snap_su_q;
    snap_st_d = snap_st_q;
    snap_mu_d = snap_mu_q;
    snap_mt_d = snap_mt_q;
    snap_hu_d = snap_hu_q;
    snap_ht_d = snap_ht_q;
    if (w_capture) begin
      snap_su_d = sec_unit;
      snap_st_d = sec_ten;
      snap_mu_d = min_unit;
      snap_mt_d = min_ten;
      snap_hu_d = hour_unit;
      snap_ht_d = hour_ten;
    end
  end

  // Select the current digit's value and its legal upper bound
  always_comb begin
    w_dig_val = 4'd0;
    w_dig_max = MAX_UNIT;
    case (idx_q)
      DIG_SEC_U:  begin w_dig_val = snap_su_q;          w_dig_max = MAX_UNIT;   end
      DIG_SEC_T:  begin w_dig_val = {1'b0, snap_st_q};  w_dig_max = MAX_TEN_MS; end
      DIG_MIN_U:  begin w_dig_val = snap_mu_q;          w_dig_max = MAX_UNIT;   end
      DIG_MIN_T:  begin w_dig_val = {1'b0, snap_mt_q};  w_dig_max = MAX_TEN_MS; end
      DIG_HOUR_U: begin w_dig_val = snap_hu_q;          w_dig_max = MAX_UNIT;   end
      DIG_HOUR_T: begin w_dig_val = {2'b00, snap_ht_q}; w_dig_max = MAX_TEN_H;  end
      default:    begin w_dig_val = 4'd0;               w_dig_max = MAX_UNIT;   end
    endcase
  end

  bcd_to_seg7 u_enc (
    .i_value (w_dig_val),
    .i_max   (w_dig_max),
    .o_seg   (w_enc_seg)
  );

  // Next pin values; anode and segments are registered together to avoid ghosting
  always_comb begin
    an_d  = ~(AN_ONE << idx_q);
    seg_d = w_enc_seg;
    if ((idx_q == DIG_HOUR_T) && (snap_ht_q == 2'd0)) begin
      seg_d = SEG_BLANK;
    end
`ifdef DC_COLON_BLINK_EN
    dp_d = ~(is_colon(idx_q) && !snap_su_q[0]);
`else
    dp_d = ~is_colon(idx_q);
`endif
    fs_d = w_capture;
  end

  // Scan timing state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= DIG_SEC_U;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame snapshot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_su_q <= '0;
      snap_st_q <= '0;
      snap_mu_q <= '0;
      snap_mt_q <= '0;
      snap_hu_q <= '0;
      snap_ht_q <= '0;
    end else begin
      snap_su_q <= snap_su_d;
      snap_st_q <= snap_st_d;
      snap_mu_q <= snap_mu_d;
      snap_mt_q <= snap_mt_d;
      snap_hu_q <= snap_hu_d;
      snap_ht_q <= snap_ht_d;
    end
  end

  // Output pin registers, display dark while in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_display_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dc_display_scan                                         |
// | Purpose  : Directed self-checking bench for dc_display_scan with      |
// |            SCAN_DIV=4; expected pin values are hand-derived.          |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_dc_display_scan;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] S4 = 7'b0011001;

  // Colon on digits 2 and 4: {d5..d0}
  localparam logic [5:0] DP_COLON = 6'b101011;
  localparam logic [5:0] DP_NONE  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sec_unit, min_unit, hour_unit;
  logic [2:0] sec_ten, min_ten;
  logic [1:0] hour_ten;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dc_display_scan #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sec_unit    (sec_unit),
    .sec_ten     (sec_ten),
    .min_unit    (min_unit),
    .min_ten     (min_ten),
    .hour_unit   (hour_unit),
    .hour_ten    (hour_ten),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed time: {ht[1:0], hu[3:0], mt[2:0], mu[3:0], st[2:0], su[3:0]}
  task automatic set_time(input logic [19:0] t);
    hour_ten  = t[19:18];
    hour_unit = t[17:14];
    min_ten   = t[13:11];
    min_unit  = t[10:7];
    sec_ten   = t[6:4];
    sec_unit  = t[3:0];
  endtask

  // One full scan frame (24 edges), pins checked after every edge.
  // segs packed {d5..d0}; inputs switch to new_t after step chg_step.
  task automatic run_frame(input string name, input logic [41:0] segs, input logic [5:0] dps,
                           input int chg_step, input logic [19:0] new_t);
    logic [5:0] one;
    logic [5:0] exp_an;
    int d;
    one = 6'b000001;
    for (int s = 0; s < 24; s++) begin
      @(posedge clk);
      #1;
      d      = s / 4;
      exp_an = ~(one << d);
      chk($sformatf("%s s%0d an", name, s), 32'(an), 32'(exp_an));
      chk($sformatf("%s s%0d seg", name, s), 32'(seg), 32'(segs[d*7 +: 7]));
      chk($sformatf("%s s%0d dp", name, s), 32'(dp), 32'(dps[d]));
      chk($sformatf("%s s%0d fs", name, s), 32'(frame_start), (s == 23) ? 32'd1 : 32'd0);
      if (s == chg_step) set_time(new_t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    // 12:34:56
    set_time({2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6});
    repeat (3) @(posedge clk);
    #1;
    chk("rst an",  32'(an),  32'h3f);
    chk("rst seg", 32'(seg), 32'h7f);
    chk("rst dp",  32'(dp),  32'd1);
    chk("rst fs",  32'(frame_start), 32'd0);

    @(negedge clk);
    reset = 1'b0;

    // Edges 1..24 after release: zero snapshot shown, first capture on edge 24
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("boot e%0d fs", e), 32'(frame_start), (e == 24) ? 32'd1 : 32'd0);
      if (e == 1) begin
        chk("boot e1 an",  32'(an),  32'(6'b111110));
        chk("boot e1 seg", 32'(seg), 32'(S0));
      end
      if (e == 24) begin
        chk("boot e24 an",  32'(an),  32'(6'b011111));
        chk("boot e24 seg", 32'(seg), 32'(SB));
      end
    end

    // Frame 1: 12:34:56
    run_frame("f1", {S1, S2, S3, S4, S5, S6}, DP_COLON, -1, 20'd0);
    // Frame 2: still 12:34:56 although inputs move to 23:59:59 mid-frame
    run_frame("f2", {S1, S2, S3, S4, S5, S6}, DP_COLON, 9,
              {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9});
    // Frame 3: 23:59:59; next inputs: hour_ten=0, hour_unit=9, sec_ten=7, min_unit=12, sec_unit=5
`ifdef DC_COLON_BLINK_EN
    run_frame("f3", {S2, S3, S5, S9, S5, S9}, DP_NONE, 2,
              {2'd0, 4'd9, 3'd0, 4'd12, 3'd7, 4'd5});
`else
    run_frame("f3", {S2, S3, S5, S9, S5, S9}, DP_COLON, 2,
              {2'd0, 4'd9, 3'd0, 4'd12, 3'd7, 4'd5});
`endif
    // Frame 4: blanked hour tens, dashes on invalid sec_ten/min_unit; next 00:00:06
`ifdef DC_COLON_BLINK_EN
    run_frame("f4", {SB, S9, S0, SD, SD, S5}, DP_NONE, 2,
              {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd6});
`else
    run_frame("f4", {SB, S9, S0, SD, SD, S5}, DP_COLON, 2,
              {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd6});
`endif
    // Frame 5: 00:00:06, colon lit in both builds (even second)
    run_frame("f5", {SB, S0, S0, S0, S0, S6}, DP_COLON, -1, 20'd0);

    // Reset mid-scan while idx==3: pins go dark before the next edge
    repeat (13) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid rst an",  32'(an),  32'h3f);
    chk("mid rst seg", 32'(seg), 32'h7f);
    chk("mid rst dp",  32'(dp),  32'd1);
    chk("mid rst fs",  32'(frame_start), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Snapshot cleared by reset: digit 0 shows 0, not the captured 6
    chk("post rst an",  32'(an),  32'(6'b111110));
    chk("post rst seg", 32'(seg), 32'(S0));
    chk("post rst fs",  32'(frame_start), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
